st2_decode: RTL

Instruction-decode stage of the multi-cycle CPU. Receives the IF→ID bus (`{pc, inst}`) from the fetch stage and reads the register file. Resolves branches and jumps back to fetch on `jbr_bus`, and emits a registered operand/control bundle to the execute stage. It is sequenced by the top-level controller through an `ID_valid`/`ID_over` handshake.

---
 rtl/st2_decode.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/st2_decode.sv
// Instruction-decode stage: captures {pc, inst}, decodes against the register file, registers the EXE bundle.
// Branch/jump resolution is compiled in only when ID_BRANCH_EN is defined; otherwise jbr_bus is tied to 0.
module st2_decode #(
  parameter logic [31:0] START_PC = 32'd0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ID_valid,
  input  logic [63:0]  IF_ID_bus,
  input  logic [31:0]  rs_value,
  input  logic [31:0]  rt_value,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic         ID_over,
  output logic [32:0]  jbr_bus,
  output logic [105:0] ID_EXE_bus,
  output logic [31:0]  ID_pc,
  output logic [31:0]  ID_inst
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
    ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5
  } alu_t;

  state_t         state;
  logic [31:0]    pcr;
  logic [31:0]    ir;
  logic           over;
  logic [105:0]   exe_bus;

  logic [5:0]     op;
  logic [5:0]     funct;
  logic [15:0]    imm;
  alu_t           d_aop;
  logic [31:0]    d_src1;
  logic [31:0]    d_src2;
  logic           d_wen;
  logic [4:0]     d_dest;

`ifdef ID_BRANCH_EN
  logic           jbr_taken;
  logic [31:0]    jbr_target;
  logic           d_taken;
  logic [31:0]    d_target;
  logic [31:0]    pcr_plus4;

  assign pcr_plus4 = pcr + 32'd4;
  assign jbr_bus   = {jbr_taken, jbr_target};
`else
  assign jbr_bus   = '0;
`endif

  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  always_comb begin
    d_aop  = ALU_ADD;
    d_src1 = '0;
    d_src2 = '0;
    d_wen  = 1'b0;
    d_dest = '0;
`ifdef ID_BRANCH_EN
    d_taken  = 1'b0;
    d_target = '0;
`endif
    // An all-zero word would otherwise match SLL; it is treated as a true NOP.
    if (ir != '0) begin
      case (op)
        6'h00: begin
          case (funct)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h2A: begin
              d_src1 = rs_value;
              d_src2 = rt_value;
              d_wen  = 1'b1;
              d_dest = ir[15:11];
              case (funct)
                6'h23:   d_aop = ALU_SUB;
                6'h24:   d_aop = ALU_AND;
                6'h25:   d_aop = ALU_OR;
                6'h2A:   d_aop = ALU_SLT;
                default: d_aop = ALU_ADD;
              endcase
            end
            6'h00: begin
              d_aop  = ALU_SLL;
              d_src1 = {27'b0, ir[10:6]};
              d_src2 = rt_value;
              d_wen  = 1'b1;
              d_dest = ir[15:11];
            end
`ifdef ID_BRANCH_EN
            6'h08: begin
              d_taken  = 1'b1;
              d_target = rs_value;
            end
`endif
            default: ;
          endcase
        end
        6'h09: begin
          d_src1 = rs_value;
          d_src2 = {{16{imm[15]}}, imm};
          d_wen  = 1'b1;
          d_dest = ir[20:16];
        end
        6'h0D: begin
          d_aop  = ALU_OR;
          d_src1 = rs_value;
          d_src2 = {16'b0, imm};
          d_wen  = 1'b1;
          d_dest = ir[20:16];
        end
        6'h0F: begin
          d_aop  = ALU_OR;
          d_src2 = {imm, 16'b0};
          d_wen  = 1'b1;
          d_dest = ir[20:16];
        end
`ifdef ID_BRANCH_EN
        6'h04, 6'h05: begin
          d_taken  = (rs_value == rt_value) ^ op[0];
          d_target = pcr_plus4 + {{14{imm[15]}}, imm, 2'b00};
        end
        6'h02: begin
          d_taken  = 1'b1;
          d_target = {pcr_plus4[31:28], ir[25:0], 2'b00};
        end
        6'h03: begin
          d_taken  = 1'b1;
          d_target = {pcr_plus4[31:28], ir[25:0], 2'b00};
          d_src1   = pcr_plus4;
          d_wen    = 1'b1;
          d_dest   = 5'd31;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      over    <= 1'b0;
      exe_bus <= '0;
      ir      <= '0;
      pcr     <= START_PC;
`ifdef ID_BRANCH_EN
      jbr_taken  <= 1'b0;
      jbr_target <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ID_valid) begin
          pcr   <= IF_ID_bus[63:32];
          ir    <= IF_ID_bus[31:0];
          state <= BUSY;
        end
        BUSY: if (ID_valid) begin
          exe_bus <= {d_aop, d_src1, d_src2, d_wen, d_dest, pcr};
`ifdef ID_BRANCH_EN
          jbr_taken  <= d_taken;
          jbr_target <= d_target;
`endif
          over  <= 1'b1;
          state <= DONE;
        end else begin
          state <= IDLE;
        end
        DONE: if (!ID_valid) begin
          over  <= 1'b0;
`ifdef ID_BRANCH_EN
          jbr_taken <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign ID_over    = over;
  assign ID_EXE_bus = exe_bus;
  assign ID_pc      = pcr;
  assign ID_inst    = ir;

endmodule
